// File: rtl/ctl_missile_pool_if.sv
// Enemy-control / draw-side bundle for the missile pool.
// Latency: none, wires only. Outputs are registered inside the pool.
// Backpressure: none. A fire with no free slot is reported on fire_drop.
interface ctl_missile_pool_if #(
  parameter int N_MISSILES = 4,
  parameter int POS_W      = 12
);
  logic                        fire;
  logic                        enemy_alive;
  logic                        freeze;
  logic [POS_W-1:0]            xpos_in;
  logic [POS_W-1:0]            ypos_in;
  logic [N_MISSILES-1:0]       hit;
  logic [N_MISSILES*POS_W-1:0] xpos_out;
  logic [N_MISSILES*POS_W-1:0] ypos_out;
  logic [N_MISSILES-1:0]       on_out;
  logic                        fire_ack;
  logic                        fire_drop;

  // Enemy control and collision logic drive the requests and see the pool state.
  modport master (
    output fire, enemy_alive, freeze, xpos_in, ypos_in, hit,
    input  xpos_out, ypos_out, on_out, fire_ack, fire_drop
  );

  // The pool itself.
  modport slave (
    input  fire, enemy_alive, freeze, xpos_in, ypos_in, hit,
    output xpos_out, ypos_out, on_out, fire_ack, fire_drop
  );
endinterface

// File: rtl/ctl_missile_pool.sv
// Pool of N enemy missiles: launch into the lowest free slot, fall per tick, retire on hit/bottom.
// Latency: fire sampled at t is answered by fire_ack/fire_drop and slot state at t+1.
// Backpressure: none. A fire with all slots busy is dropped and flagged with fire_drop.
module ctl_missile_pool #(
  parameter int N_MISSILES = 4,
  parameter int POS_W      = 12,
  parameter int STEP_DIV   = 90000,
  parameter int Y_STEP     = 1,
  parameter int Y_MAX      = 768,
  parameter int COOLDOWN   = 0
) (
  input  logic pclk,
  input  logic rst,
  ctl_missile_pool_if.slave bus
);

  localparam int CNT_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int SLOT_W = (N_MISSILES > 1) ? $clog2(N_MISSILES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN);
  localparam logic [POS_W:0]   Y_STEP_W = (POS_W + 1)'(Y_STEP);
  localparam logic [POS_W:0]   Y_MAX_W  = (POS_W + 1)'(Y_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_FLY    = 2'd2
  } slot_state_e;

  slot_state_e           state_q [N_MISSILES];
  slot_state_e           state_d [N_MISSILES];
  logic [POS_W-1:0]      x_q     [N_MISSILES];
  logic [POS_W-1:0]      x_d     [N_MISSILES];
  logic [POS_W-1:0]      y_q     [N_MISSILES];
  logic [POS_W-1:0]      y_d     [N_MISSILES];
  logic [POS_W:0]        y_next  [N_MISSILES];
  logic [N_MISSILES-1:0] on_q, on_d;
  logic                  ack_q, ack_d;
  logic                  drop_q, drop_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CD_W-1:0]       cd_q, cd_d;

  logic                  tick;
  logic                  fire_ok;
  logic                  free_found;
  logic                  accept;
  logic [SLOT_W-1:0]     alloc_idx;

  // Motion tick, slot allocation, fire ack/drop and cooldown next-state.
  always_comb begin
    tick       = (cnt_q == CNT_LAST) && !bus.freeze;
    cnt_d      = cnt_q;
    free_found = 1'b0;
    alloc_idx  = '0;
    if (!bus.freeze) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
    // Lowest-index idle slot wins; a slot retiring this cycle is not idle yet.
    for (int k = 0; k < N_MISSILES; k++) begin
      if (state_q[k] == S_IDLE && !free_found) begin
        free_found = 1'b1;
        alloc_idx  = SLOT_W'(k);
      end
    end
    fire_ok = bus.fire && bus.enemy_alive && (cd_q == '0);
    accept  = fire_ok && free_found;
    ack_d   = accept;
    drop_d  = fire_ok && !free_found;
    // Cooldown runs on the raw clock, freeze does not pause it.
    if (accept)          cd_d = CD_LOAD;
    else if (cd_q != '0) cd_d = cd_q - 1'b1;
    else                 cd_d = cd_q;
  end

  // Per-slot state machines: launch, fall on tick, retire on hit or bottom.
  always_comb begin
    for (int k = 0; k < N_MISSILES; k++) begin
      state_d[k] = state_q[k];
      x_d[k]     = x_q[k];
      y_d[k]     = y_q[k];
      y_next[k]  = {1'b0, y_q[k]} + Y_STEP_W;
      case (state_q[k])
        S_IDLE: begin
          if (accept && alloc_idx == SLOT_W'(k)) begin
            state_d[k] = S_LAUNCH;
            x_d[k]     = bus.xpos_in;
            y_d[k]     = bus.ypos_in;
          end
        end
        S_LAUNCH: begin
          state_d[k] = bus.hit[k] ? S_IDLE : S_FLY;
        end
        S_FLY: begin
          // Hit beats a coincident tick, so the collision y is kept.
          if (bus.hit[k]) begin
            state_d[k] = S_IDLE;
          end else if (tick) begin
            if (y_next[k][POS_W] || y_next[k] >= Y_MAX_W) state_d[k] = S_IDLE;
            else                                         y_d[k]     = y_next[k][POS_W-1:0];
          end
        end
        default: state_d[k] = S_IDLE;
      endcase
      on_d[k] = (state_d[k] != S_IDLE);
    end
  end

  // State registers; reset clears slots, counters and any pending pulse.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_MISSILES; k++) begin
        state_q[k] <= S_IDLE;
        x_q[k]     <= '0;
        y_q[k]     <= '0;
      end
      on_q   <= '0;
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
      cnt_q  <= '0;
      cd_q   <= '0;
    end else begin
      for (int k = 0; k < N_MISSILES; k++) begin
        state_q[k] <= state_d[k];
        x_q[k]     <= x_d[k];
        y_q[k]     <= y_d[k];
      end
      on_q   <= on_d;
      ack_q  <= ack_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      cd_q   <= cd_d;
    end
  end

  logic [N_MISSILES*POS_W-1:0] x_pk, y_pk;

  // Pack slot coordinates, slot k at bits [k*POS_W +: POS_W].
  always_comb begin
    x_pk = '0;
    y_pk = '0;
    for (int k = 0; k < N_MISSILES; k++) begin
      x_pk[k*POS_W +: POS_W] = x_q[k];
      y_pk[k*POS_W +: POS_W] = y_q[k];
    end
  end

  assign bus.xpos_out  = x_pk;
  assign bus.ypos_out  = y_pk;
  assign bus.on_out    = on_q;
  assign bus.fire_ack  = ack_q;
  assign bus.fire_drop = drop_q;

endmodule

// File: tb/tb_ctl_missile_pool.sv
// Directed bench for ctl_missile_pool: two instances, the second with a fire cooldown.
// Inputs change 1 time unit after the rising edge and outputs are sampled there too.
// Edge Ek is the k-th rising edge after reset release; ticks land on E4, E8, ...
module tb_ctl_missile_pool;
  localparam int N  = 2;
  localparam int PW = 12;

  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 pclk = ~pclk;

  ctl_missile_pool_if #(.N_MISSILES(N), .POS_W(PW)) bus1 ();
  ctl_missile_pool_if #(.N_MISSILES(N), .POS_W(PW)) bus2 ();

  ctl_missile_pool #(.N_MISSILES(N), .POS_W(PW), .STEP_DIV(4), .Y_STEP(2),
                     .Y_MAX(20), .COOLDOWN(0)) dut1 (.pclk(pclk), .rst(rst_n), .bus(bus1));
  ctl_missile_pool #(.N_MISSILES(N), .POS_W(PW), .STEP_DIV(4), .Y_STEP(2),
                     .Y_MAX(20), .COOLDOWN(5)) dut2 (.pclk(pclk), .rst(rst_n), .bus(bus2));

  wire [PW-1:0] x0 = bus1.xpos_out[PW-1:0];
  wire [PW-1:0] y0 = bus1.ypos_out[PW-1:0];
  wire [PW-1:0] x1 = bus1.xpos_out[2*PW-1:PW];
  wire [PW-1:0] y1 = bus1.ypos_out[2*PW-1:PW];

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.fire = 0; bus1.enemy_alive = 1; bus1.freeze = 0;
    bus1.xpos_in = 0; bus1.ypos_in = 0; bus1.hit = 0;
    bus2.fire = 0; bus2.enemy_alive = 1; bus2.freeze = 0;
    bus2.xpos_in = 0; bus2.ypos_in = 0; bus2.hit = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (2) step();
    checks++;
    if ({bus1.fire_ack, bus1.fire_drop, bus1.on_out, bus1.xpos_out, bus1.ypos_out} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: ack=%b drop=%b on=%b x=%h y=%h, required all 0",
               bus1.fire_ack, bus1.fire_drop, bus1.on_out, bus1.xpos_out, bus1.ypos_out);
    end
    checks++;
    if ({bus2.fire_ack, bus2.fire_drop, bus2.on_out, bus2.xpos_out, bus2.ypos_out} !== '0) begin
      errors++;
      $display("FAIL reset_dut2: ack=%b drop=%b on=%b, required all 0",
               bus2.fire_ack, bus2.fire_drop, bus2.on_out);
    end
    rst_n = 1;
  endtask

  task automatic test_single_shot();
    logic [PW-1:0] exp_y;
    do_reset();
    bus1.fire = 1; bus1.xpos_in = 100; bus1.ypos_in = 10;
    step(); // E1
    checks++;
    if ({bus1.fire_ack, bus1.fire_drop, bus1.on_out, x0, y0} !== {1'b1, 1'b0, 2'b01, 12'd100, 12'd10}) begin
      errors++;
      $display("FAIL single_launch: ack=%b drop=%b on=%b x0=%0d y0=%0d, required 1 0 01 100 10",
               bus1.fire_ack, bus1.fire_drop, bus1.on_out, x0, y0);
    end
    bus1.fire = 0; bus1.xpos_in = 0; bus1.ypos_in = 0;
    for (int k = 2; k <= 20; k++) begin
      step();
      exp_y = (k < 20) ? PW'(10 + 2 * (k / 4)) : 12'd18;
      checks++;
      if ({bus1.fire_ack, bus1.on_out[0], y0} !== {1'b0, (k < 20), exp_y}) begin
        errors++;
        $display("FAIL single_fall E%0d: ack=%b on0=%b y0=%0d, required 0 %0d %0d",
                 k, bus1.fire_ack, bus1.on_out[0], y0, (k < 20), exp_y);
      end
    end
    step();
    checks++;
    if ({bus1.on_out, x0, y0} !== {2'b00, 12'd100, 12'd18}) begin
      errors++;
      $display("FAIL single_idle_hold: on=%b x0=%0d y0=%0d, required 00 100 18", bus1.on_out, x0, y0);
    end
  endtask

  task automatic test_pool_full();
    do_reset();
    bus1.fire = 1; bus1.xpos_in = 50; bus1.ypos_in = 0;
    step(); // E1
    checks++;
    if ({bus1.fire_ack, bus1.fire_drop, bus1.on_out} !== {1'b1, 1'b0, 2'b01}) begin
      errors++;
      $display("FAIL full_first: ack=%b drop=%b on=%b, required 1 0 01", bus1.fire_ack, bus1.fire_drop, bus1.on_out);
    end
    bus1.xpos_in = 60; bus1.ypos_in = 4;
    step(); // E2
    checks++;
    if ({bus1.fire_ack, bus1.fire_drop, bus1.on_out, x1, y1} !== {1'b1, 1'b0, 2'b11, 12'd60, 12'd4}) begin
      errors++;
      $display("FAIL full_second: ack=%b drop=%b on=%b x1=%0d y1=%0d, required 1 0 11 60 4",
               bus1.fire_ack, bus1.fire_drop, bus1.on_out, x1, y1);
    end
    bus1.xpos_in = 70; bus1.ypos_in = 8;
    step(); // E3
    checks++;
    if ({bus1.fire_ack, bus1.fire_drop, bus1.on_out, x0, y0, x1, y1} !==
        {1'b0, 1'b1, 2'b11, 12'd50, 12'd0, 12'd60, 12'd4}) begin
      errors++;
      $display("FAIL full_drop: ack=%b drop=%b on=%b x0=%0d y0=%0d x1=%0d y1=%0d, required 0 1 11 50 0 60 4",
               bus1.fire_ack, bus1.fire_drop, bus1.on_out, x0, y0, x1, y1);
    end
    bus1.fire = 0;
    step(); // E4, tick
    checks++;
    if ({bus1.fire_ack, bus1.fire_drop, bus1.on_out, y0, y1} !== {1'b0, 1'b0, 2'b11, 12'd2, 12'd6}) begin
      errors++;
      $display("FAIL full_after: ack=%b drop=%b on=%b y0=%0d y1=%0d, required 0 0 11 2 6",
               bus1.fire_ack, bus1.fire_drop, bus1.on_out, y0, y1);
    end
  endtask

  task automatic test_hit_priority();
    do_reset();
    bus1.fire = 1; bus1.xpos_in = 30; bus1.ypos_in = 10;
    step(); // E1
    bus1.xpos_in = 31; bus1.ypos_in = 0;
    step(); // E2
    bus1.fire = 0;
    repeat (9) step(); // E3..E11
    checks++;
    if ({bus1.on_out, y0, y1} !== {2'b11, 12'd14, 12'd4}) begin
      errors++;
      $display("FAIL hit_setup: on=%b y0=%0d y1=%0d, required 11 14 4", bus1.on_out, y0, y1);
    end
    // Hit on a tick edge, with a fire that cannot yet reuse the retiring slot.
    bus1.hit = 2'b01; bus1.fire = 1; bus1.xpos_in = 40; bus1.ypos_in = 2;
    step(); // E12
    checks++;
    if ({bus1.fire_ack, bus1.fire_drop, bus1.on_out, y0, y1} !== {1'b0, 1'b1, 2'b10, 12'd14, 12'd6}) begin
      errors++;
      $display("FAIL hit_tick: ack=%b drop=%b on=%b y0=%0d y1=%0d, required 0 1 10 14 6",
               bus1.fire_ack, bus1.fire_drop, bus1.on_out, y0, y1);
    end
    bus1.hit = 2'b00;
    step(); // E13
    checks++;
    if ({bus1.fire_ack, bus1.fire_drop, bus1.on_out, x0, y0, y1} !==
        {1'b1, 1'b0, 2'b11, 12'd40, 12'd2, 12'd6}) begin
      errors++;
      $display("FAIL hit_reuse: ack=%b drop=%b on=%b x0=%0d y0=%0d y1=%0d, required 1 0 11 40 2 6",
               bus1.fire_ack, bus1.fire_drop, bus1.on_out, x0, y0, y1);
    end
    bus1.fire = 0; bus1.hit = 2'b01;
    step(); // E14, slot0 hit while in LAUNCH
    checks++;
    if ({bus1.fire_ack, bus1.on_out, x0, y0} !== {1'b0, 2'b10, 12'd40, 12'd2}) begin
      errors++;
      $display("FAIL hit_launch: ack=%b on=%b x0=%0d y0=%0d, required 0 10 40 2", bus1.fire_ack, bus1.on_out, x0, y0);
    end
    bus1.hit = 2'b00;
  endtask

  task automatic test_freeze();
    do_reset();
    bus1.fire = 1; bus1.xpos_in = 5; bus1.ypos_in = 0;
    step(); // E1
    bus1.fire = 0;
    repeat (8) step(); // E2..E9
    checks++;
    if ({bus1.on_out, y0} !== {2'b01, 12'd4}) begin
      errors++;
      $display("FAIL freeze_setup: on=%b y0=%0d, required 01 4", bus1.on_out, y0);
    end
    bus1.freeze = 1;
    for (int k = 10; k <= 19; k++) begin
      step();
      checks++;
      if ({bus1.on_out, x0, y0} !== {2'b01, 12'd5, 12'd4}) begin
        errors++;
        $display("FAIL freeze_hold E%0d: on=%b x0=%0d y0=%0d, required 01 5 4", k, bus1.on_out, x0, y0);
      end
    end
    bus1.freeze = 0;
    repeat (2) step(); // E20, E21
    checks++;
    if (y0 !== 12'd4) begin
      errors++;
      $display("FAIL freeze_resume_early: y0=%0d, required 4", y0);
    end
    step(); // E22, counter resumed from 1
    checks++;
    if (y0 !== 12'd6) begin
      errors++;
      $display("FAIL freeze_resume_tick: y0=%0d, required 6", y0);
    end
  endtask

  task automatic test_cooldown();
    do_reset();
    bus2.fire = 1; bus2.xpos_in = 7; bus2.ypos_in = 0;
    for (int k = 1; k <= 13; k++) begin
      step();
      checks++;
      if ({bus2.fire_ack, bus2.fire_drop} !== {(k == 1 || k == 7), (k == 13)}) begin
        errors++;
        $display("FAIL cooldown E%0d: ack=%b drop=%b, required %0d %0d",
                 k, bus2.fire_ack, bus2.fire_drop, (k == 1 || k == 7), (k == 13));
      end
    end
    bus2.fire = 0;
    checks++;
    if (bus2.on_out !== 2'b11) begin
      errors++;
      $display("FAIL cooldown_slots: on=%b, required 11", bus2.on_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus1.fire = 1; bus1.xpos_in = 9; bus1.ypos_in = 3;
    step(); // E1
    bus1.xpos_in = 11; bus1.ypos_in = 5;
    step(); // E2
    step(); // E3, pool full
    checks++;
    if ({bus1.on_out, bus1.fire_drop} !== {2'b11, 1'b1}) begin
      errors++;
      $display("FAIL areset_setup: on=%b drop=%b, required 11 1", bus1.on_out, bus1.fire_drop);
    end
    bus1.fire = 0;
    #1 rst_n = 0;
    #1;
    checks++;
    if ({bus1.fire_ack, bus1.fire_drop, bus1.on_out, bus1.xpos_out, bus1.ypos_out} !== '0) begin
      errors++;
      $display("FAIL areset_immediate: ack=%b drop=%b on=%b x=%h y=%h, required all 0",
               bus1.fire_ack, bus1.fire_drop, bus1.on_out, bus1.xpos_out, bus1.ypos_out);
    end
    repeat (2) step();
    rst_n = 1;
    bus1.enemy_alive = 0; bus1.fire = 1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({bus1.fire_ack, bus1.fire_drop, bus1.on_out} !== 4'b0000) begin
        errors++;
        $display("FAIL dead_enemy E%0d: ack=%b drop=%b on=%b, required 0 0 00",
                 k, bus1.fire_ack, bus1.fire_drop, bus1.on_out);
      end
    end
    bus1.enemy_alive = 1;
    step();
    checks++;
    if ({bus1.fire_ack, bus1.on_out} !== {1'b1, 2'b01}) begin
      errors++;
      $display("FAIL alive_again: ack=%b on=%b, required 1 01", bus1.fire_ack, bus1.on_out);
    end
    bus1.fire = 0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_pool_full();
    test_hit_priority();
    test_freeze();
    test_cooldown();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
